// File: rtl/bpb_gshare.sv
// Gshare branch predictor: direct-mapped BTB plus GHR-xor-indexed PHT, trained at branch resolution.
// Lookup is combinational (zero latency); updates commit on the clock edge unless stalled and are dropped otherwise.
module bpb_gshare #(
  parameter int INDEX_WIDTH = 6,
  parameter int HIST_WIDTH  = 6,
  parameter int CTR_WIDTH   = 2,
  parameter int TAG_WIDTH   = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] instr_addr_i,
  output logic        predict_hit_o,
  output logic        predict_taken_o,
  output logic [31:0] predict_addr_o,
  input  logic        update_valid_i,
  input  logic [31:0] update_addr_i,
  input  logic        update_taken_i,
  input  logic [31:0] update_target_i,
  input  logic        update_pred_taken_i,
  input  logic [31:0] update_pred_addr_i,
  output logic        mispredict_o,
  output logic [15:0] miss_count_o
);

  localparam int ENTRIES = 2 ** INDEX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((2 ** (CTR_WIDTH - 1)) - 1);

  typedef logic [INDEX_WIDTH-1:0] idx_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  btb_entry_t            btb_q [ENTRIES];
  logic [CTR_WIDTH-1:0]  pht_q [ENTRIES];
  logic [HIST_WIDTH-1:0] ghr_q;
  logic                  mispredict_q;
  logic [15:0]           miss_count_q;

  idx_t ghr_ext;

  always_comb begin
    ghr_ext = '0;
    ghr_ext[HIST_WIDTH-1:0] = ghr_q;
  end

  // Lookup path
  idx_t                 lk_idx;
  idx_t                 lk_pidx;
  logic [TAG_WIDTH-1:0] lk_tag;
  btb_entry_t           lk_entry;
  logic                 lk_hit;
  logic                 lk_taken;
  logic [31:0]          lk_seq;

  assign lk_idx   = instr_addr_i[INDEX_WIDTH+1:2];
  assign lk_tag   = instr_addr_i[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];
  assign lk_pidx  = lk_idx ^ ghr_ext;
  assign lk_entry = btb_q[lk_idx];
  assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign lk_taken = lk_hit && pht_q[lk_pidx][CTR_WIDTH-1];
  assign lk_seq   = instr_addr_i + 32'd4;

  assign predict_hit_o   = lk_hit && !flush_i;
  assign predict_taken_o = lk_taken && !flush_i;
  assign predict_addr_o  = (lk_taken && !flush_i) ? lk_entry.target : lk_seq;

  // Update path
  logic                 upd_accept;
  idx_t                 upd_idx;
  idx_t                 upd_pidx;
  logic [TAG_WIDTH-1:0] upd_tag;
  logic [CTR_WIDTH-1:0] upd_ctr;
  logic [CTR_WIDTH-1:0] upd_ctr_next;
  logic                 upd_mis;
  btb_entry_t           upd_entry;

  assign upd_accept = update_valid_i && !stall_i;
  assign upd_idx    = update_addr_i[INDEX_WIDTH+1:2];
  assign upd_tag    = update_addr_i[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];
  assign upd_pidx   = upd_idx ^ ghr_ext;
  assign upd_ctr    = pht_q[upd_pidx];
  assign upd_entry  = '{valid: 1'b1, tag: upd_tag, target: update_target_i};
  assign upd_mis    = (update_pred_taken_i != update_taken_i) ||
                      (update_pred_taken_i && update_taken_i &&
                       (update_pred_addr_i != update_target_i));

  always_comb begin
    upd_ctr_next = upd_ctr;
    if (update_taken_i && (upd_ctr != CTR_MAX)) begin
      upd_ctr_next = upd_ctr + CTR_ONE;
    end else if (!update_taken_i && (upd_ctr != '0)) begin
      upd_ctr_next = upd_ctr - CTR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= CTR_INIT;
      end
    end else if (upd_accept) begin
      pht_q[upd_pidx] <= upd_ctr_next;
    end
  end

  // Only taken branches allocate, so not-taken resolutions never evict a useful target.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '0;
      end
    end else if (upd_accept && update_taken_i) begin
      btb_q[upd_idx] <= upd_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr_q        <= '0;
      mispredict_q <= 1'b0;
      miss_count_q <= '0;
    end else begin
      mispredict_q <= upd_accept && upd_mis;
      if (upd_accept) begin
        ghr_q <= HIST_WIDTH'({ghr_q, update_taken_i});
      end
      if (upd_accept && upd_mis && (miss_count_q != 16'hFFFF)) begin
        miss_count_q <= miss_count_q + 16'd1;
      end
    end
  end

  assign mispredict_o = mispredict_q;
  assign miss_count_o = miss_count_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_addr_i[1:0], instr_addr_i[31:INDEX_WIDTH+TAG_WIDTH+2],
                              update_addr_i[1:0], update_addr_i[31:INDEX_WIDTH+TAG_WIDTH+2]};

endmodule

// File: doc/bpb_gshare.md
BPB_GSHARE -- requirements
Module: bpb_gshare

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 6, table index bits; ENTRIES = 2**INDEX_WIDTH.
REQ-002 SHALL have parameter HIST_WIDTH, default 6, global history bits; legal range 1..INDEX_WIDTH.
REQ-003 SHALL have parameter CTR_WIDTH, default 2, PHT saturating-counter bits; legal range >= 2.
REQ-004 SHALL have parameter TAG_WIDTH, default 8, partial address tag stored per BTB entry.
REQ-005 SHALL have port clk_i input 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni input 1, reset, asynchronous, active-low.
REQ-007 SHALL have port stall_i input 1, freezes all state.
REQ-008 SHALL have port flush_i input 1, suppresses prediction outputs.
REQ-009 SHALL have port instr_addr_i input 32, lookup PC.
REQ-010 SHALL have port predict_hit_o output 1, BTB tag hit.
REQ-011 SHALL have port predict_taken_o output 1, predicted taken.
REQ-012 SHALL have port predict_addr_o output 32, predicted next PC.
REQ-013 SHALL have port update_valid_i input 1, a resolved branch is presented.
REQ-014 SHALL have port update_addr_i input 32, resolved branch PC.
REQ-015 SHALL have port update_taken_i input 1, actual direction.
REQ-016 SHALL have port update_target_i input 32, actual taken target.
REQ-017 SHALL have port update_pred_taken_i input 1, direction predicted earlier for this branch.
REQ-018 SHALL have port update_pred_addr_i input 32, next PC predicted earlier.
REQ-019 SHALL have port mispredict_o output 1, registered mispredict pulse.
REQ-020 SHALL have port miss_count_o output 16, saturating mispredict count.

Function
REQ-021 SHALL hold a direct-mapped BTB of ENTRIES {valid, tag, target[31:0]}; index = addr[INDEX_WIDTH+1:2], tag = addr[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2].
REQ-022 SHALL hold a PHT of ENTRIES CTR_WIDTH-bit counters; PHT index = addr[INDEX_WIDTH+1:2] XOR zero-extended GHR.
REQ-023 SHALL hold a HIST_WIDTH-bit GHR updated only at resolution (non-speculative), so no repair logic is needed.
REQ-024 Lookup SHALL be combinational, zero latency: hit = valid && tag match; taken = hit && counter MSB.
REQ-025 predict_addr_o SHALL be the BTB target when taken, else instr_addr_i+4 modulo 2**32 (0xFFFFFFFC -> 0x00000000).
REQ-026 While flush_i=1, predict_hit_o and predict_taken_o SHALL be 0 and predict_addr_o SHALL be instr_addr_i+4; state is unaffected.
REQ-027 An update SHALL be accepted on a rising edge when update_valid_i=1 and stall_i=0; otherwise it is dropped and the source must hold it.
REQ-028 On an accepted update, the PHT counter SHALL be indexed with the pre-update GHR and SHALL saturate at both ends: increment if taken (max 2**CTR_WIDTH-1), decrement if not taken (min 0).
REQ-029 On an accepted update, the GHR SHALL become {GHR[HIST_WIDTH-2:0], update_taken_i}.
REQ-030 On an accepted taken update, the BTB entry SHALL be written: valid=1, tag, target = update_target_i, overwriting any alias.
REQ-031 A not-taken update SHALL NOT allocate or invalidate a BTB entry.
REQ-032 Lookup and update in the same cycle, same index, SHALL see pre-update contents (no bypass).
REQ-033 An accepted update SHALL be a mispredict when pred_taken != taken, or when both are 1 and pred_addr != target.
REQ-034 mispredict_o SHALL pulse for exactly one cycle, the cycle after the accepted mispredicted update.
REQ-035 miss_count_o SHALL increment in the same edge as the mispredict_o pulse and SHALL hold at 0xFFFF.
REQ-036 stall_i=1 SHALL hold all tables, the GHR and the counter; mispredict_o SHALL be 0 in the following cycle.

Reset
REQ-037 rst_ni=0 SHALL immediately, without a clock, clear all BTB valid bits, GHR=0, miss_count_o=0 and mispredict_o=0.
REQ-038 rst_ni=0 SHALL set every PHT counter to weakly-not-taken, 2**(CTR_WIDTH-1)-1 (01 at default).
REQ-039 Outputs SHALL reach reset values asynchronously even if reset asserts mid-update; the first accepted update is on the first rising edge after rst_ni rises.

Verification
REQ-040 Reset check: lookup 0x00400000 -> hit 0, taken 0, addr 0x00400004; lookup 0xFFFFFFFC -> addr 0x00000000.
REQ-041 Training check: 6 taken updates at 0x00400080 (target 0x00400200) -> GHR=0x3F; then 2 taken updates at 0x00400010 (target 0x00400100) -> counter 0x3B 01->10->11; a 3rd taken update -> stays 11; lookup 0x00400010 -> hit 1, taken 1, addr 0x00400100.
REQ-042 Alias/no-allocate check: from reset, not-taken update at 0x00400010 -> lookup hit 0; taken update at 0x00400410 (same index, different tag) -> lookup 0x00400010 hit 0, lookup 0x00400410 hit 1.
REQ-043 Stall/flush check: update_valid_i=1 with stall_i=1 -> GHR, tables and miss_count_o unchanged, mispredict_o 0; flush_i=1 on a trained PC -> taken 0, addr = PC+4.
REQ-044 Mispredict check: update with pred_taken=1, taken=0 -> mispredict_o=1 next cycle only, miss_count_o=1; taken update with matching direction but pred_addr 0x10 vs target 0x20 -> count 2; forcing 65536 mispredicts -> holds 0xFFFF.
REQ-045 Async reset check: rst_ni pulled low between edges after training -> outputs equal REQ-040 values before the next clock edge.
